// File: rtl/ll_ctrl_pkg.sv
// Shared types and helpers for the Lunar Lander input-side controllers.
package ll_ctrl_pkg;

  typedef enum logic [1:0] {
    ANALOG   = 2'd0,
    DPAD     = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  // The game core treats 0xFF specially, so thrust tops out one below it.
  localparam logic [7:0] THRUST_MAX = 8'd254;

  // Clamp a 9-bit signed thrust candidate into the legal 0..254 range.
  function automatic logic [7:0] sat_thrust(input logic signed [8:0] v);
    if (v < 9'sd0) begin
      return 8'd0;
    end else if (v > 9'sd254) begin
      return THRUST_MAX;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/ll_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module ll_tick_gen #(
  parameter int DIV = 98425
) (
  input  logic clk_25,
  input  logic RESET_L,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Tick is decoded from the count rather than registered so it lines up
  // with the cycle in which the count sits at its last value.
  assign tick = (r_cnt == LAST);

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ll_thrust_sched.sv
// Thrust source selector with slew-limited handover and OSD overlay timer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ANALOG   | thrust tracks the saturated stick target every cycle
// DPAD     | thrust tracks the D-pad integrator (acc)
// HANDOVER | thrust slews toward the selected source by SLEW_STEP/tick
module ll_thrust_sched
  import ll_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 98425,
  parameter int SLEW_STEP = 8,
  parameter int OSD_HOLD  = 250000000
) (
  input  logic              clk_25,
  input  logic              RESET_L,
  input  logic              mode_dpad,
  input  logic signed [7:0] analog_y,
  input  logic              thr_up,
  input  logic              thr_down,
  input  logic              game_sel_l,
  output logic [7:0]        thrust,
  output logic              handover,
  output logic              osd_en
);

  localparam logic [7:0] STEP8 = 8'(SLEW_STEP);
  localparam int OSD_W = $clog2(OSD_HOLD + 1);
  localparam logic [OSD_W-1:0] OSD_LOAD = OSD_W'(OSD_HOLD);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_thrust;
  logic [7:0]       w_thrust_nxt;
  logic [7:0]       r_acc;
  logic [7:0]       w_acc_int;
  logic [7:0]       w_acc_nxt;
  logic             r_handover;
  logic [OSD_W-1:0] r_osd_cnt;

  logic              w_tick;
  logic signed [8:0] w_a_raw;
  logic [7:0]        w_a_tgt;
  logic [7:0]        w_ho_target;
  logic              w_ho_up;
  logic [7:0]        w_ho_dist;
  logic [7:0]        w_ho_step;

  ll_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk_25 (clk_25),
    .RESET_L(RESET_L),
    .tick   (w_tick)
  );

  // Stick forward (-128) maps to full thrust; 127 - y spans 0..255 before clamping.
  assign w_a_raw = 9'sd127 - $signed({analog_y[7], analog_y});
  assign w_a_tgt = sat_thrust(w_a_raw);

  assign w_ho_target = mode_dpad ? r_acc : w_a_tgt;
  assign w_ho_up     = (w_ho_target > r_thrust);
  assign w_ho_dist   = w_ho_up ? (w_ho_target - r_thrust) : (r_thrust - w_ho_target);
  assign w_ho_step   = (w_ho_dist > STEP8) ? STEP8 : w_ho_dist;

  // D-pad integrator: one count per tick, saturating, conflicting requests hold.
  always_comb begin
    w_acc_int = r_acc;
    if (w_tick) begin
      if (thr_up && !thr_down && (r_acc < THRUST_MAX)) begin
        w_acc_int = r_acc + 8'd1;
      end else if (thr_down && !thr_up && (r_acc != 8'd0)) begin
        w_acc_int = r_acc - 8'd1;
      end
    end
  end

  // Next-state, next-thrust and acc-load decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_thrust_nxt = r_thrust;
    w_acc_nxt    = w_acc_int;
    case (r_state)
      ANALOG: begin
        if (mode_dpad) begin
          // Hold thrust on the switch cycle so acc and thrust start equal.
          w_state_nxt = DPAD;
          w_acc_nxt   = r_thrust;
        end else begin
          w_thrust_nxt = w_a_tgt;
        end
      end
      DPAD: begin
        if (!mode_dpad) begin
          w_state_nxt = (w_a_tgt == r_thrust) ? ANALOG : HANDOVER;
        end else begin
          w_thrust_nxt = r_acc;
        end
      end
      HANDOVER: begin
        if (r_thrust == w_ho_target) begin
          if (mode_dpad) begin
            w_state_nxt = DPAD;
            w_acc_nxt   = r_thrust;
          end else begin
            w_state_nxt = ANALOG;
          end
        end else if (w_tick) begin
          w_thrust_nxt = w_ho_up ? (r_thrust + w_ho_step) : (r_thrust - w_ho_step);
        end
      end
      default: begin
        w_state_nxt = HANDOVER;
      end
    endcase
  end

  // FSM and datapath registers; handover flag mirrors the registered state.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state    <= HANDOVER;
      r_thrust   <= 8'd0;
      r_acc      <= 8'd0;
      r_handover <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_thrust   <= w_thrust_nxt;
      r_acc      <= w_acc_nxt;
      r_handover <= (w_state_nxt == HANDOVER);
    end
  end

  // Overlay timer: reload while SELECT is held, then count down to zero.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      r_osd_cnt <= '0;
    end else if (!game_sel_l) begin
      r_osd_cnt <= OSD_LOAD;
    end else if (r_osd_cnt != '0) begin
      r_osd_cnt <= r_osd_cnt - 1'b1;
    end
  end

  assign thrust   = r_thrust;
  assign handover = r_handover;
  assign osd_en   = (r_osd_cnt != '0);

endmodule
